vga_fb_arbiter: RTL and testbench

- Shares one single-port framebuffer RAM (RGB444, FB_WIDTH x FB_HEIGHT, upscaled by 2^SCALE_LOG2) between two users:
  - display scanout, which has fixed, deadline-driven slots;
  - a drawing-engine write port with valid/ready handshake, which gets all remaining cycles.
- Also sequences a hardware framebuffer clear.
- Sits between vga_sync_generator and the colour pins, on the 25 MHz pixel clock.

---
 rtl/vga_pkg.sv | 52 +++++
 rtl/vga_scan_pipe.sv | 71 +++++++
 rtl/vga_fb_arbiter.sv | 170 +++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA framebuffer path.
//   - 640x480@60 timing constants (pixels, porches, sync widths, totals)
//   - framebuffer geometry: FB_WIDTH x FB_HEIGHT, upscaled by 2^SCALE_LOG2
//   - RGB444 field widths and packed colour type
//   - arbiter FSM state encoding
//   - helper computing a row-major framebuffer index
package vga_pkg;

    // 640x480 @ 60 Hz, 25 MHz pixel clock
    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Framebuffer geometry
    localparam int FB_WIDTH   = 160;
    localparam int FB_HEIGHT  = 120;
    localparam int SCALE_LOG2 = 2;
    localparam int FB_DEPTH   = FB_WIDTH * FB_HEIGHT;

    // RGB444 fields
    localparam int R_BITS   = 4;
    localparam int G_BITS   = 4;
    localparam int B_BITS   = 4;
    localparam int RGB_BITS = R_BITS + G_BITS + B_BITS;

    typedef struct packed {
        logic [R_BITS-1:0] r;
        logic [G_BITS-1:0] g;
        logic [B_BITS-1:0] b;
    } rgb444_t;

    // Arbiter state: IDLE serves the writer, CLEAR owns all non-scan cycles
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_CLEAR = 1'b1
    } arb_state_e;

    // Row-major framebuffer index, 32-bit so callers truncate explicitly
    function automatic logic [31:0] fb_index(input logic [31:0] col,
                                             input logic [31:0] row,
                                             input int          width);
        return row * 32'(width) + col;
    endfunction

endpackage

// File: rtl/vga_scan_pipe.sv
// Scanout pipeline: aligns RAM read data with the delayed sync signals.
// Colour and syncs appear exactly two cycles after the x/y/sync inputs.
//
// Ports:
//   clk, rst          pixel clock, synchronous active-high reset
//   scan_slot_i       this cycle issues a framebuffer read
//   video_active_i    sync generator's active-video flag
//   hsync_i, vsync_i  active-low syncs from the sync generator
//   rdata_i           RAM read data (valid the cycle after a scan slot)
//   hsync_o, vsync_o  syncs delayed by two registers
//   colour_o          registered RGB444 colour, 0 outside active video
module vga_scan_pipe
    import vga_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                scan_slot_i,
    input  logic                video_active_i,
    input  logic                hsync_i,
    input  logic                vsync_i,
    input  logic [RGB_BITS-1:0] rdata_i,
    output logic                hsync_o,
    output logic                vsync_o,
    output rgb444_t             colour_o
);

    logic          slot_q;
    logic          active_q;
    logic [1:0]    hsync_q;
    logic [1:0]    vsync_q;
    rgb444_t       pix_hold_q, pix_hold_d;
    rgb444_t       colour_q, colour_d;

    // The RAM answers one cycle after the slot, so the capture is qualified
    // by the delayed slot flag. Using the bypass value (pix_hold_d) in the
    // colour stage keeps the total latency at two cycles; the colour
    // register doubles as the second delay stage of video_active.
    always_comb begin
        pix_hold_d = pix_hold_q;
        if (slot_q) begin
            pix_hold_d = rgb444_t'(rdata_i);
        end
        colour_d = '0;
        if (active_q) begin
            colour_d = pix_hold_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q     <= 1'b0;
            active_q   <= 1'b0;
            hsync_q    <= 2'b11;
            vsync_q    <= 2'b11;
            pix_hold_q <= '0;
            colour_q   <= '0;
        end else begin
            slot_q     <= scan_slot_i;
            active_q   <= video_active_i;
            hsync_q    <= {hsync_q[0], hsync_i};
            vsync_q    <= {vsync_q[0], vsync_i};
            pix_hold_q <= pix_hold_d;
            colour_q   <= colour_d;
        end
    end

    assign hsync_o  = hsync_q[1];
    assign vsync_o  = vsync_q[1];
    assign colour_o = colour_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter between display scanout, a hardware clear engine
// and a drawing-engine write port. Strict priority: scan > clear > writer.
// Scan slots fall on every 2^SCALE_LOG2-th active pixel and are never
// delayed; every other cycle goes to the clear (while running) or writer.
//
// Handshake: wr_ready is a pure function of the scan slot and FSM state
// (never of wr_valid); a request is consumed on any cycle where
// wr_valid && wr_ready. Out-of-range coordinates are consumed without a
// RAM access.
//
// Ports:
//   clk, rst                     pixel clock, synchronous active-high reset
//   video_active_in, x_loc, y_loc, hsync_in, vsync_in   sync generator
//   hsync_out, vsync_out, red, green, blue              to the pins
//   wr_valid, wr_ready, wr_x, wr_y, wr_data             writer port
//   clear_req, clear_color, clear_busy                  clear control
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata      single-port RAM
//   dbg_state                    current arbiter state
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int FB_WIDTH   = vga_pkg::FB_WIDTH,
    parameter int FB_HEIGHT  = vga_pkg::FB_HEIGHT,
    parameter int SCALE_LOG2 = vga_pkg::SCALE_LOG2,
    parameter int X_BITS     = 10,
    parameter int Y_BITS     = 10,
    parameter int ADDR_BITS  = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 video_active_in,
    input  logic [X_BITS-1:0]    x_loc,
    input  logic [Y_BITS-1:0]    y_loc,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    output logic                 hsync_out,
    output logic                 vsync_out,
    output logic [3:0]           red,
    output logic [3:0]           green,
    output logic [3:0]           blue,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [7:0]           wr_x,
    input  logic [6:0]           wr_y,
    input  logic [11:0]          wr_data,
    input  logic                 clear_req,
    input  logic [11:0]          clear_color,
    output logic                 clear_busy,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [11:0]          mem_wdata,
    input  logic [11:0]          mem_rdata,
    output arb_state_e           dbg_state
);

    localparam int                   DEPTH     = FB_WIDTH * FB_HEIGHT;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

    arb_state_e           state_q, state_d;
    logic [ADDR_BITS-1:0] clr_addr_q, clr_addr_d;
    logic [11:0]          clr_color_q, clr_color_d;

    logic                 scan_slot;
    logic [ADDR_BITS-1:0] scan_addr;
    logic [ADDR_BITS-1:0] wr_addr;
    logic                 wr_in_range;
    rgb444_t              colour;

    // One read per upscaled pixel: the first screen column of each group
    assign scan_slot = video_active_in && (x_loc[SCALE_LOG2-1:0] == '0);

    // Constant multiplies; synthesis reduces these to shift-adds
    assign scan_addr = ADDR_BITS'(fb_index(32'(x_loc) >> SCALE_LOG2,
                                           32'(y_loc) >> SCALE_LOG2,
                                           FB_WIDTH));
    assign wr_addr   = ADDR_BITS'(fb_index(32'(wr_x), 32'(wr_y), FB_WIDTH));

    assign wr_in_range = (32'(wr_x) < 32'(FB_WIDTH)) &&
                         (32'(wr_y) < 32'(FB_HEIGHT));

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        clr_color_d = clr_color_q;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        wr_ready    = !scan_slot && (state_q == ARB_IDLE);

        // RAM port mux in strict priority order
        if (scan_slot) begin
            mem_en   = 1'b1;
            mem_addr = scan_addr;
        end else if (state_q == ARB_CLEAR) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = clr_addr_q;
            mem_wdata = clr_color_q;
        end else if (wr_valid && wr_in_range) begin
            // Reaching here implies wr_ready; out-of-range requests are
            // still consumed by the handshake but touch no RAM.
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end

        case (state_q)
            ARB_IDLE: begin
                if (clear_req) begin
                    state_d     = ARB_CLEAR;
                    clr_addr_d  = '0;
                    clr_color_d = clear_color;
                end
            end
            ARB_CLEAR: begin
                // Advance only on cycles where the clear actually wrote
                if (!scan_slot) begin
                    if (clr_addr_q == LAST_ADDR) begin
                        state_d = ARB_IDLE;
                    end else begin
                        clr_addr_d = clr_addr_q + ADDR_BITS'(1);
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // No RAM access of any kind in a reset cycle
        if (rst) begin
            mem_en = 1'b0;
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            clr_addr_q  <= '0;
            clr_color_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            clr_color_q <= clr_color_d;
        end
    end

    assign clear_busy = (state_q == ARB_CLEAR);
    assign dbg_state  = state_q;

    vga_scan_pipe u_scan_pipe (
        .clk            (clk),
        .rst            (rst),
        .scan_slot_i    (scan_slot),
        .video_active_i (video_active_in),
        .hsync_i        (hsync_in),
        .vsync_i        (vsync_in),
        .rdata_i        (mem_rdata),
        .hsync_o        (hsync_out),
        .vsync_o        (vsync_out),
        .colour_o       (colour)
    );

    assign red   = colour.r;
    assign green = colour.g;
    assign blue  = colour.b;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;
    import vga_pkg::*;

    localparam int FBW   = 160;
    localparam int FBH   = 120;
    localparam int DEPTH = FBW * FBH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic        rst = 1'b1;
    logic        video_active_in = 1'b0;
    logic [9:0]  x_loc = '0;
    logic [9:0]  y_loc = '0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        hsync_out, vsync_out;
    logic [3:0]  red, green, blue;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  wr_x = '0;
    logic [6:0]  wr_y = '0;
    logic [11:0] wr_data = '0;
    logic        clear_req = 1'b0;
    logic [11:0] clear_color = '0;
    logic        clear_busy;
    logic        mem_en, mem_we;
    logic [14:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata = '0;
    arb_state_e  dbg_state;

    vga_fb_arbiter dut (
        .clk(clk), .rst(rst),
        .video_active_in(video_active_in), .x_loc(x_loc), .y_loc(y_loc),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .red(red), .green(green), .blue(blue),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .clear_req(clear_req), .clear_color(clear_color), .clear_busy(clear_busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    // ---------------- RAM (environment) ----------------
    logic [11:0] tb_ram [0:32767] = '{default: 12'h000};
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= tb_ram[mem_addr];
        if (mem_en && mem_we)  tb_ram[mem_addr] <= mem_wdata;
    end

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Expected RAM image, clear progress, last value fetched by scanout and
    // the two-deep colour/sync expectation history.
    typedef struct packed {
        logic        hs;
        logic        vs;
        logic [11:0] col;
    } pipe_t;
    localparam pipe_t PIPE_RST = '{hs: 1'b1, vs: 1'b1, col: 12'h000};

    logic [11:0] model_ram [0:32767] = '{default: 12'h000};
    bit          chk_en     = 0;
    bit          clearing_m = 0;
    int          clr_ptr_m  = 0;
    logic [11:0] clr_col_m  = '0;
    logic [11:0] last_rd_m  = '0;
    pipe_t       p1 = PIPE_RST;
    pipe_t       p2 = PIPE_RST;

    always @(negedge clk) begin
        bit   slot_m, e_ready, e_en, e_we;
        int   e_addr;
        logic [11:0] e_wd;
        if (chk_en) begin
            slot_m  = video_active_in && (int'(x_loc) % 4 == 0);
            e_ready = !slot_m && !clearing_m;
            e_en = 0; e_we = 0; e_addr = 0; e_wd = '0;
            if (!rst) begin
                if (slot_m) begin
                    e_en = 1;
                    e_addr = (int'(y_loc) / 4) * FBW + int'(x_loc) / 4;
                end else if (clearing_m) begin
                    e_en = 1; e_we = 1; e_addr = clr_ptr_m; e_wd = clr_col_m;
                end else if (wr_valid && int'(wr_x) < FBW && int'(wr_y) < FBH) begin
                    e_en = 1; e_we = 1; e_addr = int'(wr_y) * FBW + int'(wr_x); e_wd = wr_data;
                end
            end
            chk("wr_ready", 32'(wr_ready), 32'(e_ready));
            chk("clear_busy", 32'(clear_busy), 32'(clearing_m));
            chk("mem_en", 32'(mem_en), 32'(e_en));
            if (e_en) begin
                chk("mem_we", 32'(mem_we), 32'(e_we));
                chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            end
            if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
            chk("colour", 32'({red, green, blue}), 32'(p2.col));
            chk("hsync_out", 32'(hsync_out), 32'(p2.hs));
            chk("vsync_out", 32'(vsync_out), 32'(p2.vs));

            if (rst) begin
                clearing_m = 0;
                last_rd_m  = '0;
                p1 = PIPE_RST;
                p2 = PIPE_RST;
            end else begin
                if (slot_m) last_rd_m = model_ram[e_addr];
                p2 = p1;
                p1 = '{hs: hsync_in, vs: vsync_in,
                       col: video_active_in ? last_rd_m : 12'h000};
                if (e_we) model_ram[e_addr] = e_wd;
                if (clearing_m) begin
                    if (!slot_m) begin
                        if (clr_ptr_m == DEPTH - 1) clearing_m = 0;
                        else clr_ptr_m++;
                    end
                end else if (clear_req) begin
                    clearing_m = 1;
                    clr_ptr_m  = 0;
                    clr_col_m  = clear_color;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic va, input int x, input int y,
                         input logic hs, input logic vs, input logic wv,
                         input int wx, input int wy, input logic [11:0] wd,
                         input logic cr, input logic [11:0] cc);
        @(posedge clk); #1;
        rst = r; video_active_in = va; x_loc = 10'(x); y_loc = 10'(y);
        hsync_in = hs; vsync_in = vs; wr_valid = wv; wr_x = 8'(wx); wr_y = 7'(wy);
        wr_data = wd; clear_req = cr; clear_color = cc;
        @(negedge clk);
    endtask

    task automatic drive_rand(input logic wv_en);
        drive(1'b0, 1'($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              wv_en & 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 175)), int'($urandom_range(0, 127)),
              12'($urandom), 1'b0, 12'h000);
    endtask

    // ---------------- stimulus + directed literal checks ----------------
    initial begin
        int acc, reads, wcnt, slot_w, rdy_hi, first_a, last_a, bad, n;
        bit done;

        // Reset: two cycles, model engaged from the second
        drive(1'b1, 0, 0, 0, 1, 1, 0, 0, 0, 12'h0, 0, 12'h0);
        chk_en = 1;
        drive(1'b1, 0, 0, 0, 1, 1, 0, 0, 0, 12'h0, 0, 12'h0);
        chk("rst_colour", 32'({red, green, blue}), 32'h000);
        chk("rst_hsync", 32'(hsync_out), 32'h1);
        chk("rst_vsync", 32'(vsync_out), 32'h1);
        chk("rst_busy", 32'(clear_busy), 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(ARB_IDLE));

        // Put F0A at FB (1,2) = address 321 through the writer port
        drive(1'b0, 0, 0, 0, 1, 1, 1, 1, 2, 12'hF0A, 0, 12'h0);
        chk("wr321_addr", 32'(mem_addr), 32'd321);
        chk("wr321_we", 32'(mem_we), 32'h1);

        // Scan slot at x=4,y=8: read 321, colour two cycles later
        drive(1'b0, 1, 4, 8, 0, 1, 0, 0, 0, 12'h0, 0, 12'h0);
        chk("slot_addr", 32'(mem_addr), 32'd321);
        chk("slot_we", 32'(mem_we), 32'h0);
        chk("slot_en", 32'(mem_en), 32'h1);
        drive(1'b0, 1, 5, 8, 1, 1, 0, 0, 0, 12'h0, 0, 12'h0);
        chk("lat1_colour", 32'({red, green, blue}), 32'h000);
        drive(1'b0, 1, 6, 8, 1, 1, 0, 0, 0, 12'h0, 0, 12'h0);
        chk("lat2_red", 32'(red), 32'hF);
        chk("lat2_green", 32'(green), 32'h0);
        chk("lat2_blue", 32'(blue), 32'hA);
        chk("lat2_hsync", 32'(hsync_out), 32'h0);

        // Write presented on a slot cycle is stalled one cycle
        drive(1'b0, 1, 8, 8, 1, 1, 1, 5, 3, 12'h123, 0, 12'h0);
        chk("slotwr_ready", 32'(wr_ready), 32'h0);
        drive(1'b0, 1, 9, 8, 1, 1, 1, 5, 3, 12'h123, 0, 12'h0);
        chk("slotwr_ready2", 32'(wr_ready), 32'h1);
        chk("slotwr_we", 32'(mem_we), 32'h1);
        chk("slotwr_addr", 32'(mem_addr), 32'd485);
        chk("slotwr_data", 32'(mem_wdata), 32'h123);

        // Blanking: writer owns every cycle
        acc = 0; reads = 0;
        for (int i = 0; i < 160; i++) begin
            drive(1'b0, 0, i, 490, 1, 1, 1, int'($urandom_range(0, 159)),
                  int'($urandom_range(0, 119)), 12'($urandom), 0, 12'h0);
            if (wr_valid && wr_ready) acc++;
            if (mem_en && !mem_we) reads++;
        end
        chk("blank_accepts", 32'(acc), 32'd160);
        chk("blank_reads", 32'(reads), 32'd0);
        chk("blank_colour", 32'({red, green, blue}), 32'h000);

        // Out-of-range write: consumed, no RAM access
        drive(1'b0, 0, 0, 490, 1, 1, 1, 170, 10, 12'h555, 0, 12'h0);
        chk("oor_ready", 32'(wr_ready), 32'h1);
        chk("oor_en", 32'(mem_en), 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) drive_rand(1'b1);

        // Full clear under random video and writer pressure
        drive(1'b0, 0, 0, 490, 1, 0, 0, 0, 0, 12'h0, 1, 12'h00F);
        chk("clr_start_busy", 32'(clear_busy), 32'h0);
        wcnt = 0; slot_w = 0; rdy_hi = 0; first_a = -1; last_a = -1; done = 0;
        for (n = 0; n < 40000; n++) begin
            drive_rand(1'b1);
            if (!clear_busy) begin done = 1; break; end
            if (mem_en && mem_we) begin
                if (wcnt == 0) first_a = int'(mem_addr);
                last_a = int'(mem_addr);
                wcnt++;
                if (video_active_in && x_loc[1:0] == 2'b00) slot_w++;
            end
            if (wr_ready) rdy_hi++;
        end
        chk("clr_finished", 32'(done), 32'h1);
        chk("clr_writes", 32'(wcnt), 32'd19200);
        chk("clr_first_addr", 32'(first_a), 32'd0);
        chk("clr_last_addr", 32'(last_a), 32'd19199);
        chk("clr_slot_writes", 32'(slot_w), 32'd0);
        chk("clr_ready_high", 32'(rdy_hi), 32'd0);
        chk("clr_busy_after", 32'(clear_busy), 32'h0);
        bad = 0;
        for (int a = 0; a < DEPTH; a++) if (tb_ram[a] != 12'h00F) bad++;
        chk("clr_ram_image", 32'(bad), 32'd0);

        for (int i = 0; i < 500; i++) drive_rand(1'b1);

        // Reset in the middle of a clear
        drive(1'b0, 0, 0, 490, 1, 1, 0, 0, 0, 12'h0, 1, 12'h7A3);
        done = 0;
        for (n = 0; n < 5000; n++) begin
            drive_rand(1'b1);
            if (clr_ptr_m >= 500) begin done = 1; break; end
        end
        chk("midclr_reached", 32'(done), 32'h1);
        drive(1'b1, 1, 0, 10, 0, 0, 1, 3, 3, 12'hABC, 0, 12'h0);
        drive(1'b0, 0, 0, 490, 1, 1, 0, 0, 0, 12'h0, 0, 12'h0);
        chk("midclr_state", 32'(dbg_state), 32'(ARB_IDLE));
        chk("midclr_busy", 32'(clear_busy), 32'h0);
        chk("midclr_en", 32'(mem_en), 32'h0);
        chk("midclr_colour", 32'({red, green, blue}), 32'h000);
        chk("midclr_hsync", 32'(hsync_out), 32'h1);
        chk("midclr_vsync", 32'(vsync_out), 32'h1);

        for (int i = 0; i < 300; i++) drive_rand(1'b1);

        // End-to-end: RAM image written by the DUT vs the model's image
        @(posedge clk); #1;
        bad = 0;
        for (int a = 0; a < 32768; a++) if (tb_ram[a] !== model_ram[a]) bad++;
        chk("ram_image", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
